jump_branch_decode_stage: RTL and testbench

//  Parametrised, registered control-flow decode stage for the RV32I core.

---
 rtl/jump_branch_decode_stage_pkg.sv | 37 +++
 rtl/jump_branch_decode_stage_if.sv | 45 ++++
 rtl/jump_branch_decode_stage_fifo.sv | 83 ++++++++
 rtl/jump_branch_decode_stage.sv | 111 +++++++++++
 tb/tb_jump_branch_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jump_branch_decode_stage_pkg.sv
// Shared opcodes, jump classes and the default decoded-record layout for the
// control-flow decode stage.
package jump_branch_decode_stage_pkg;

    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam int DEF_XLEN = 32;

    typedef enum logic [1:0] {
        JC_NONE   = 2'd0,
        JC_JAL    = 2'd1,
        JC_JALR   = 2'd2,
        JC_BRANCH = 2'd3
    } jump_ctrl_e;

    // Decoded record at the default 32-bit datapath width. The top level
    // builds an identical layout at its own XLEN and hands it to the FIFO.
    typedef struct packed {
        jump_ctrl_e          jc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [DEF_XLEN-1:0] imm;
        logic [DEF_XLEN-1:0] target;
        logic [DEF_XLEN-1:0] link;
        logic                illegal;
    } jb_dec_t;

    // funct3 values 2 and 3 are unassigned in the branch opcode space.
    function automatic logic branch_f3_illegal(input logic [2:0] f3);
        return (f3 == 3'd2) || (f3 == 3'd3);
    endfunction

endpackage

// File: rtl/jump_branch_decode_stage_if.sv
// Bundle of the fetch-side and execute-side handshakes of the decode stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready never depends combinationally on valid. in_ready is a
// function of the registered FIFO occupancy only. flush discards the FIFO
// contents and any transfer that would have happened on that edge.
interface jump_branch_decode_stage_if #(
    parameter int XLEN = 32
) ();
    import jump_branch_decode_stage_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    jump_ctrl_e       out_jc;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [2:0]       out_funct3;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_link;
    logic             out_illegal;

    // Driver side: fetch plus the consumer's ready.
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_jc, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_target, out_link, out_illegal
    );

    // Decode-stage side.
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_jc, out_rd, out_rs1, out_rs2,
               out_funct3, out_imm, out_target, out_link, out_illegal
    );

endinterface

// File: rtl/jump_branch_decode_stage_fifo.sv
// First-word-fall-through synchronous FIFO for decoded records. The head
// entry is visible on o_data whenever o_valid is high; o_ready reflects only
// the registered occupancy, so a full FIFO refuses a push even on a cycle
// where it is also being popped.
module jb_dec_fifo
    import jump_branch_decode_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = jb_dec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_push,
    input  T     i_data,
    output logic o_ready,
    input  logic i_pop,
    output logic o_valid,
    output T     o_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign o_ready = (r_count != FULL_CNT);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rptr];

    // A flush cancels both sides of the handshake for its cycle.
    assign w_push = i_push && o_ready && !i_flush;
    assign w_pop  = i_pop  && o_valid && !i_flush;

    // Storage: cleared on reset so the outputs read as zero until first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush returns to empty without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jump_branch_decode_stage.sv
// Control-flow decode stage: turns a fetched JAL/JALR/branch instruction and
// its pc into a decoded record (registers, immediate, jump class, target and
// link) and queues it in a small FWFT FIFO toward execute.
module jump_branch_decode_stage
    import jump_branch_decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter bit EN_BRANCH = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    jump_branch_decode_stage_if.slave bus
);

    typedef struct packed {
        jump_ctrl_e      jc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic            illegal;
    } dec_rec_t;

    // Pure decode of one instruction. Unknown opcodes still produce a record
    // (jc=NONE, imm=0) so the instruction stream stays in order downstream.
    function automatic dec_rec_t decode(input logic [31:0] instr,
                                        input logic [XLEN-1:0] pc);
        dec_rec_t        r;
        logic [XLEN-1:0] imm_j;
        logic [XLEN-1:0] imm_i;
        logic [XLEN-1:0] imm_b;
        imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
        imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                 instr[11:8], 1'b0};

        r        = '0;
        r.jc     = JC_NONE;
        r.rs1    = instr[19:15];
        r.funct3 = instr[14:12];
        r.link   = pc + XLEN'(4);

        case (instr[6:0])
            OP_JAL: begin
                r.jc     = JC_JAL;
                r.rd     = instr[11:7];
                r.imm    = imm_j;
                r.target = pc + imm_j;
            end
            OP_JALR: begin
                // Target depends on rs1, which is only known in execute.
                r.jc      = JC_JALR;
                r.rd      = instr[11:7];
                r.imm     = imm_i;
                r.illegal = (instr[14:12] != 3'd0);
            end
            OP_BRANCH: begin
                if (EN_BRANCH) begin
                    r.jc      = JC_BRANCH;
                    r.rs2     = instr[24:20];
                    r.imm     = imm_b;
                    r.target  = pc + imm_b;
                    r.illegal = branch_f3_illegal(instr[14:12]);
                end
            end
            default: begin
            end
        endcase
        return r;
    endfunction

    dec_rec_t w_dec;
    dec_rec_t w_head;
    logic     w_in_ready;
    logic     w_out_valid;

    assign w_dec = decode(bus.in_instr, bus.in_pc);

    jb_dec_fifo #(
        .DEPTH (DEPTH),
        .T     (dec_rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_push  (bus.in_valid),
        .i_data  (w_dec),
        .o_ready (w_in_ready),
        .i_pop   (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_head)
    );

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_jc      = w_head.jc;
    assign bus.out_rd      = w_head.rd;
    assign bus.out_rs1     = w_head.rs1;
    assign bus.out_rs2     = w_head.rs2;
    assign bus.out_funct3  = w_head.funct3;
    assign bus.out_imm     = w_head.imm;
    assign bus.out_target  = w_head.target;
    assign bus.out_link    = w_head.link;
    assign bus.out_illegal = w_head.illegal;

endmodule

// File: tb/tb_jump_branch_decode_stage.sv
// Bench for the control-flow decode stage: directed scenarios plus a
// randomized stream checked against an instruction-level reference model.
module tb_jump_branch_decode_stage;

    localparam int DEPTH = 2;
    localparam int RW    = 117;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    jump_branch_decode_stage_if #(.XLEN(32)) bus ();
    jump_branch_decode_stage_if #(.XLEN(32)) bus_nb ();

    jump_branch_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_BRANCH(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    jump_branch_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_BRANCH(1'b0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    // Reference: record fields from the instruction-set rules, immediates
    // assembled with signed integer arithmetic. rs2 only matters for branches.
    function automatic logic [RW-1:0] model_rec(input logic [31:0] instr,
                                                input logic [31:0] pc,
                                                input bit en_br);
        int          imm;
        logic [1:0]  jc;
        logic [4:0]  rd;
        logic [4:0]  rs2m;
        logic [31:0] tgt;
        logic        ill;
        logic [6:0]  op;
        logic [2:0]  f3;
        op = instr[6:0];
        f3 = instr[14:12];
        jc = 2'd0; rd = 5'd0; rs2m = 5'd0; imm = 0; tgt = 32'd0; ill = 1'b0;
        if (op == 7'h6F) begin
            jc  = 2'd1;
            rd  = instr[11:7];
            imm = (instr[31] ? -1048576 : 0) + int'(instr[19:12]) * 4096
                + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
            tgt = pc + 32'(imm);
        end else if (op == 7'h67) begin
            jc  = 2'd2;
            rd  = instr[11:7];
            imm = (instr[31] ? -2048 : 0) + int'(instr[30:20]);
            ill = (f3 != 3'd0);
        end else if (op == 7'h63 && en_br) begin
            jc   = 2'd3;
            rs2m = instr[24:20];
            imm  = (instr[31] ? -4096 : 0) + int'(instr[7]) * 2048
                 + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2;
            tgt  = pc + 32'(imm);
            ill  = (f3 == 3'd2) || (f3 == 3'd3);
        end
        return {jc, rd, instr[19:15], rs2m, f3, 32'(imm), tgt, pc + 32'd4, ill};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {bus.out_jc, bus.out_rd, bus.out_rs1,
                (bus.out_jc == 2'd3) ? bus.out_rs2 : 5'd0, bus.out_funct3,
                bus.out_imm, bus.out_target, bus.out_link, bus.out_illegal};
    endfunction

    // Driver: present one instruction for a single edge (stage assumed ready).
    task automatic push_and_look(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Driver: pop the head over the next edge.
    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_out_valid got=%0b exp=0", bus.out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        total++; if (bus.out_jc !== 2'd0) begin bad++; $display("FAIL reset_jc got=%0d exp=0", bus.out_jc); end
        total++; if (bus.out_imm !== 32'd0) begin bad++; $display("FAIL reset_imm got=%h exp=0", bus.out_imm); end
        total++; if (bus.out_target !== 32'd0) begin bad++; $display("FAIL reset_target got=%h exp=0", bus.out_target); end
        total++; if (bus.out_link !== 32'd0) begin bad++; $display("FAIL reset_link got=%h exp=0", bus.out_link); end
    endtask

    task automatic test_jal();
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h100;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jal_pre_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL jal_valid got=%0b exp=1", bus.out_valid); end
        total++; if (bus.out_jc !== 2'd1) begin bad++; $display("FAIL jal_jc got=%0d exp=1", bus.out_jc); end
        total++; if (bus.out_rd !== 5'd1) begin bad++; $display("FAIL jal_rd got=%0d exp=1", bus.out_rd); end
        total++; if (bus.out_imm !== 32'd8) begin bad++; $display("FAIL jal_imm got=%h exp=8", bus.out_imm); end
        total++; if (bus.out_target !== 32'h108) begin bad++; $display("FAIL jal_target got=%h exp=108", bus.out_target); end
        total++; if (bus.out_link !== 32'h104) begin bad++; $display("FAIL jal_link got=%h exp=104", bus.out_link); end
        pop_one();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jal_popped got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_jalr();
        push_and_look(32'hFFC08067, 32'h40);
        total++; if (bus.out_jc !== 2'd2) begin bad++; $display("FAIL jalr_jc got=%0d exp=2", bus.out_jc); end
        total++; if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL jalr_rd got=%0d exp=0", bus.out_rd); end
        total++; if (bus.out_rs1 !== 5'd1) begin bad++; $display("FAIL jalr_rs1 got=%0d exp=1", bus.out_rs1); end
        total++; if (bus.out_imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL jalr_imm got=%h exp=fffffffc", bus.out_imm); end
        total++; if (bus.out_link !== 32'h44) begin bad++; $display("FAIL jalr_link got=%h exp=44", bus.out_link); end
        total++; if (bus.out_target !== 32'h0) begin bad++; $display("FAIL jalr_target got=%h exp=0", bus.out_target); end
        total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL jalr_illegal got=%0b exp=0", bus.out_illegal); end
        pop_one();
        push_and_look(32'hFFC09067, 32'h40);
        total++; if (bus.out_illegal !== 1'b1) begin bad++; $display("FAIL jalr_f3_illegal got=%0b exp=1", bus.out_illegal); end
        total++; if (bus.out_funct3 !== 3'd1) begin bad++; $display("FAIL jalr_f3 got=%0d exp=1", bus.out_funct3); end
        pop_one();
    endtask

    task automatic test_branch();
        push_and_look(32'hFE208CE3, 32'h200);
        total++; if (bus.out_jc !== 2'd3) begin bad++; $display("FAIL br_jc got=%0d exp=3", bus.out_jc); end
        total++; if (bus.out_rs1 !== 5'd1) begin bad++; $display("FAIL br_rs1 got=%0d exp=1", bus.out_rs1); end
        total++; if (bus.out_rs2 !== 5'd2) begin bad++; $display("FAIL br_rs2 got=%0d exp=2", bus.out_rs2); end
        total++; if (bus.out_imm !== 32'hFFFFFFF8) begin bad++; $display("FAIL br_imm got=%h exp=fffffff8", bus.out_imm); end
        total++; if (bus.out_target !== 32'h1F8) begin bad++; $display("FAIL br_target got=%h exp=1f8", bus.out_target); end
        total++; if (bus.out_rd !== 5'd0) begin bad++; $display("FAIL br_rd got=%0d exp=0", bus.out_rd); end
        pop_one();
        @(negedge clk);
        bus_nb.in_valid = 1'b1; bus_nb.in_instr = 32'hFE208CE3; bus_nb.in_pc = 32'h200;
        @(negedge clk);
        bus_nb.in_valid = 1'b0;
        total++; if (bus_nb.out_valid !== 1'b1) begin bad++; $display("FAIL nobr_valid got=%0b exp=1", bus_nb.out_valid); end
        total++; if (bus_nb.out_jc !== 2'd0) begin bad++; $display("FAIL nobr_jc got=%0d exp=0", bus_nb.out_jc); end
        total++; if (bus_nb.out_imm !== 32'd0) begin bad++; $display("FAIL nobr_imm got=%h exp=0", bus_nb.out_imm); end
        total++; if (bus_nb.out_target !== 32'd0) begin bad++; $display("FAIL nobr_target got=%h exp=0", bus_nb.out_target); end
        bus_nb.out_ready = 1'b1;
        @(negedge clk);
        bus_nb.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_tgt [3];
        int          n_out;
        bit          acc_now;
        bit          c_acc;
        exp_tgt[0] = 32'h1008; exp_tgt[1] = 32'h2008; exp_tgt[2] = 32'h3008;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h1000;
        @(negedge clk);
        bus.in_pc = 32'h2000;
        @(negedge clk);
        bus.in_pc = 32'h3000;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b exp=0", bus.in_ready); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready got=%0b exp=0", bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        n_out = 0; c_acc = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc_now = 1'b0;
            if (bus.out_valid) begin
                total++;
                if (n_out > 2) begin
                    bad++; $display("FAIL bp_extra got_target=%h exp=no_record", bus.out_target);
                end else if (bus.out_target !== exp_tgt[n_out]) begin
                    bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", n_out, bus.out_target, exp_tgt[n_out]);
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) acc_now = 1'b1;
            @(negedge clk);
            if (acc_now) begin bus.in_valid = 1'b0; c_acc = 1'b1; end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (n_out != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", n_out); end
        total++; if (!c_acc) begin bad++; $display("FAIL bp_third_accept got=0 exp=1"); end
    endtask

    task automatic test_flush();
        for (int n = 1; n <= 2; n++) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < n; k++) push_and_look(32'h008000EF, 32'h500 + 32'(k) * 32'h10);
            bus.in_valid = 1'b1; bus.in_instr = 32'h008000EF; bus.in_pc = 32'h7770;
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0; bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid n=%0d got=%0b exp=0", n, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready n=%0d got=%0b exp=1", n, bus.in_ready); end
            bus.out_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak n=%0d target=%h exp=no_record", n, bus.out_target); end
            end
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        push_and_look(32'h008000EF, 32'h900);
        push_and_look(32'h008000EF, 32'h910);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%0b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_empty got=%0b exp=0", bus.out_valid); end
        push_and_look(32'h008000EF, 32'hFFFFFFFC);
        total++; if (bus.out_target !== 32'h4) begin bad++; $display("FAIL wrap_target got=%h exp=4", bus.out_target); end
        total++; if (bus.out_link !== 32'h0) begin bad++; $display("FAIL wrap_link got=%h exp=0", bus.out_link); end
        pop_one();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_popped got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_random();
        int          pct;
        int          sel;
        bit          m_valid;
        bit          m_ready;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [RW-1:0] e;
        logic [6:0]  other_ops [4];
        other_ops[0] = 7'h13; other_ops[1] = 7'h33; other_ops[2] = 7'h03; other_ops[3] = 7'h37;
        exp_q.delete();
        pct = 50;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc % 100 == 0) pct = $urandom_range(10, 95);
            sel   = $urandom_range(0, 3);
            instr = $urandom;
            case (sel)
                0:       instr[6:0] = 7'h6F;
                1:       instr[6:0] = 7'h67;
                2:       instr[6:0] = 7'h63;
                default: instr[6:0] = other_ops[$urandom_range(0, 3)];
            endcase
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.in_instr  = instr;
            bus.in_pc     = pc;
            bus.out_ready = ($urandom_range(0, 99) < pct);
            bus.flush     = ($urandom_range(0, 49) == 0);
            #1;
            m_valid = (exp_q.size() != 0);
            m_ready = (exp_q.size() < DEPTH);
            total++; if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, bus.out_valid, m_valid); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, bus.in_ready, m_ready); end
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && bus.out_ready) begin
                    e = exp_q.pop_front();
                    total++;
                    if (observed() !== e) begin
                        bad++; $display("FAIL rnd_record cyc=%0d got=%h exp=%h", cyc, observed(), e);
                    end
                end
                if (bus.in_valid && m_ready) exp_q.push_back(model_rec(instr, pc, 1'b1));
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
        bus_nb.flush = 1'b0; bus_nb.in_valid = 1'b0; bus_nb.in_instr = 32'd0; bus_nb.in_pc = 32'd0; bus_nb.out_ready = 1'b0;
        test_reset();
        test_jal();
        test_jalr();
        test_branch();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog time=%0t exp=finished_earlier", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
